// File: rtl/servo_pwm_pkg.sv
// Shared definitions for the servo PWM generator and decoder: decoder states,
// servo position constants and default accepted pulse-width limits.
package servo_pwm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } dec_state_t;

  // Servo positions in 1 us units, shared with the generator side.
  localparam int SERVO_RETRACTED = 1500;
  localparam int SERVO_EXTENDED  = 700;

  localparam int DEF_MIN_WIDTH = 500;
  localparam int DEF_MAX_WIDTH = 2000;

endpackage : servo_pwm_pkg

// File: rtl/servo_pwm_decoder_sync_edge.sv
// Two-flop synchronizer for an asynchronous line plus a history flop that
// yields single-cycle rise/fall pulses on the synchronized level.
module sync_edge (
  input  logic clk_1M,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk_1M) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;
  assign fall  = ~s2 & s3;

endmodule : sync_edge

// File: rtl/servo_pwm_decoder.sv
// Measures high pulses of a servo PWM line in clock units, strobes accepted
// and rejected widths, and tracks train presence and position stability.
module servo_pwm_decoder
  import servo_pwm_pkg::*;
#(
  parameter int WIDTH_SZ       = 11,
  parameter int MIN_WIDTH      = DEF_MIN_WIDTH,
  parameter int MAX_WIDTH      = DEF_MAX_WIDTH,
  parameter int TIMEOUT_CTR_SZ = 15,
  parameter int TIMEOUT        = 20000,
  parameter int STABLE_CNT     = 4,
  parameter int TOL            = 8
) (
  input  logic                clk_1M,
  input  logic                rst,
  input  logic                pwm_in,
  output logic [WIDTH_SZ-1:0] width,
  output logic                width_valid,
  output logic                width_err,
  output logic                active,
  output logic                stable
);

  localparam int MATCH_SZ = $clog2(STABLE_CNT + 1);

  localparam logic [WIDTH_SZ-1:0]       W_MAX     = {WIDTH_SZ{1'b1}};
  localparam logic [WIDTH_SZ-1:0]       W_ONE     = WIDTH_SZ'(1);
  localparam logic [WIDTH_SZ-1:0]       W_MIN_C   = WIDTH_SZ'(MIN_WIDTH);
  localparam logic [WIDTH_SZ-1:0]       W_MAX_C   = WIDTH_SZ'(MAX_WIDTH);
  localparam logic [WIDTH_SZ:0]         TOL_C     = (WIDTH_SZ + 1)'(TOL);
  localparam logic [TIMEOUT_CTR_SZ-1:0] TO_C      = TIMEOUT_CTR_SZ'(TIMEOUT);
  localparam logic [TIMEOUT_CTR_SZ-1:0] TO_ONE    = TIMEOUT_CTR_SZ'(1);
  localparam logic [MATCH_SZ-1:0]       MATCH_MAX = MATCH_SZ'(STABLE_CNT);
  localparam logic [MATCH_SZ-1:0]       MATCH_ONE = MATCH_SZ'(1);

  logic level, rise, fall;

  sync_edge u_sync (
    .clk_1M (clk_1M),
    .rst    (rst),
    .din    (pwm_in),
    .level  (level),
    .rise   (rise),
    .fall   (fall)
  );

  dec_state_t                state, state_nxt;
  logic [WIDTH_SZ-1:0]       wcnt, wcnt_nxt;
  logic [TIMEOUT_CTR_SZ-1:0] to_cnt, to_nxt, to_inc;
  logic [MATCH_SZ-1:0]       match_cnt, match_nxt;
  logic                      active_nxt;
  logic [1:0]                warm;
  logic                      warm_done;
  logic                      evaluate, timeout, accept, reject, close;
  logic [WIDTH_SZ:0]         diff;

  // The synchronizer flops are cleared by reset, so its output is only a
  // genuine sample of the line once two post-reset edges have filled it.
  assign warm_done = warm[1];
  assign to_inc    = (to_cnt == TO_C) ? to_cnt : to_cnt + TO_ONE;

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    to_nxt    = to_cnt;
    evaluate  = 1'b0;
    unique case (state)
      IDLE: begin
        to_nxt = '0;
        if (warm_done && !level) state_nxt = LOW;
      end
      LOW: begin
        if (rise) begin
          state_nxt = HIGH;
          wcnt_nxt  = W_ONE;
          to_nxt    = '0;
        end else begin
          to_nxt = to_inc;
        end
      end
      HIGH: begin
        to_nxt = to_inc;
        if (fall) begin
          state_nxt = LOW;
          evaluate  = 1'b1;
        end else if (wcnt != W_MAX) begin
          wcnt_nxt = wcnt + W_ONE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // A pulse ending on the timeout cycle is still evaluated; timeout only
    // overrides where the train goes next.
    timeout = (state != IDLE) && (to_nxt == TO_C);
    if (timeout) state_nxt = IDLE;
  end

  always_comb begin
    accept = evaluate && (wcnt != W_MAX) && (wcnt >= W_MIN_C) && (wcnt <= W_MAX_C);
    reject = evaluate && !accept;
    diff   = ({1'b0, wcnt} >= {1'b0, width}) ? ({1'b0, wcnt} - {1'b0, width})
                                             : ({1'b0, width} - {1'b0, wcnt});
    close  = (diff <= TOL_C);

    match_nxt = match_cnt;
    if (accept) begin
      if ((match_cnt != '0) && close)
        match_nxt = (match_cnt == MATCH_MAX) ? match_cnt : match_cnt + MATCH_ONE;
      else
        match_nxt = MATCH_ONE;
    end else if (reject) begin
      match_nxt = '0;
    end

    active_nxt = active;
    if (accept) active_nxt = 1'b1;

    if (timeout) begin
      match_nxt  = '0;
      active_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk_1M) begin
    if (rst) begin
      state       <= IDLE;
      wcnt        <= '0;
      to_cnt      <= '0;
      match_cnt   <= '0;
      warm        <= '0;
      width       <= '0;
      width_valid <= 1'b0;
      width_err   <= 1'b0;
      active      <= 1'b0;
      stable      <= 1'b0;
    end else begin
      state       <= state_nxt;
      wcnt        <= wcnt_nxt;
      to_cnt      <= to_nxt;
      match_cnt   <= match_nxt;
      warm        <= {warm[0], 1'b1};
      width_valid <= accept;
      width_err   <= reject;
      active      <= active_nxt;
      stable      <= (match_nxt == MATCH_MAX);
      if (accept) width <= wcnt;
    end
  end

endmodule : servo_pwm_decoder
